// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction prefetcher.
package fetch_pkg;

    localparam int unsigned BUF_BYTES_DEF  = 128;
    localparam int unsigned LINE_BYTES_DEF = 64;
    localparam int unsigned WINDOW_DEF     = 15;
    localparam int unsigned BEAT_BYTES     = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        ACTIVE,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_ring.sv
// Byte ring buffer: one aligned 8-byte write port, one WINDOW-byte read port wrapping at BUF_BYTES.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_BYTES = BUF_BYTES_DEF,
    parameter int unsigned WINDOW    = WINDOW_DEF
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(BUF_BYTES)-1:0]  wr_idx,
    input  logic [8*BEAT_BYTES-1:0]       wr_data,
    input  logic [$clog2(BUF_BYTES)-1:0]  rd_idx,
    output logic [8*WINDOW-1:0]           rd_data
);

    localparam int unsigned IDX_W = $clog2(BUF_BYTES);

    logic [7:0] mem [BUF_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BEAT_BYTES; i++)
                mem[wr_idx + IDX_W'(i)] <= wr_data[8*i +: 8];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < WINDOW; i++)
            rd_data[8*i +: 8] = mem[rd_idx + IDX_W'(i)];
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: fetches 64-byte lines into a byte ring and presents a
// 15-byte decode window at dec_rip; redirect flushes the ring and drains any open burst.
module inst_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_BYTES  = BUF_BYTES_DEF,
    parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
    parameter int unsigned WINDOW     = WINDOW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         entry,
    input  logic                redirect,
    input  logic [63:0]         redirect_rip,
    output logic                reqcyc,
    output logic [63:0]         req,
    input  logic                reqack,
    input  logic                respcyc,
    input  logic [63:0]         resp,
    output logic                respack,
    output logic                dec_valid,
    output logic [8*WINDOW-1:0] dec_bytes,
    output logic [63:0]         dec_rip,
    input  logic [3:0]          dec_consume
);

    localparam int unsigned IDX_W      = $clog2(BUF_BYTES);
    localparam int unsigned PTR_W      = IDX_W + 1;
    localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);
    localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
    localparam int unsigned BEATS      = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned BEAT_W     = $clog2(BEATS);
    localparam logic [63:0] LINE_MASK  = ~64'(LINE_BYTES - 1);

    fetch_state_t      state;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, diff, count;
    logic [BEAT_W-1:0] beat_cnt, skip_beats;
    logic [63:0]       fetch_line;
    logic              last_beat, beat_keep;

    // rd_ptr starts up to 7 bytes ahead of wr_ptr; that negative distance reads as empty
    assign diff      = wr_ptr - rd_ptr;
    assign count     = (diff > PTR_W'(BUF_BYTES)) ? '0 : diff;
    assign dec_valid = count >= PTR_W'(WINDOW);
    assign respack   = respcyc;
    assign last_beat = beat_cnt == BEAT_W'(BEATS - 1);
    assign beat_keep = respcyc && !redirect && (state == WAITING || state == ACTIVE)
                       && beat_cnt >= skip_beats;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            reqcyc   <= 1'b0;
            req      <= '0;
            wr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            reqcyc <= 1'b0;
            if (state == IDLE) begin
                beat_cnt <= '0;
                state    <= (reqcyc && reqack) ? DRAIN : IDLE;
            end else begin
                if (respcyc)
                    beat_cnt <= beat_cnt + 1'b1;
                state <= (respcyc && last_beat) ? IDLE : DRAIN;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (reqcyc) begin
                        if (reqack) begin
                            reqcyc <= 1'b0;
                            state  <= WAITING;
                        end
                    end else if (count <= PTR_W'(BUF_BYTES - LINE_BYTES)) begin
                        reqcyc <= 1'b1;
                        req    <= fetch_line;
                    end
                end
                WAITING, ACTIVE: begin
                    if (respcyc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_keep)
                            wr_ptr <= wr_ptr + PTR_W'(BEAT_BYTES);
                        state <= last_beat ? IDLE : ACTIVE;
                    end
                end
                DRAIN: begin
                    if (respcyc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat)
                            state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Start-address state re-samples entry on every clock while reset is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_line <= entry & LINE_MASK;
            skip_beats <= entry[LINE_SHIFT-1:OFF_W];
            rd_ptr     <= PTR_W'(entry[OFF_W-1:0]);
            dec_rip    <= entry;
        end else if (redirect) begin
            fetch_line <= redirect_rip & LINE_MASK;
            skip_beats <= redirect_rip[LINE_SHIFT-1:OFF_W];
            rd_ptr     <= PTR_W'(redirect_rip[OFF_W-1:0]);
            dec_rip    <= redirect_rip;
        end else begin
            rd_ptr  <= rd_ptr + PTR_W'(dec_consume);
            dec_rip <= dec_rip + 64'(dec_consume);
            if (state == ACTIVE && respcyc && last_beat) begin
                fetch_line <= fetch_line + 64'(LINE_BYTES);
                skip_beats <= '0;
            end
        end
    end

    fetch_ring #(
        .BUF_BYTES (BUF_BYTES),
        .WINDOW    (WINDOW)
    ) u_ring (
        .clk     (clk),
        .wr_en   (beat_keep),
        .wr_idx  (wr_ptr[IDX_W-1:0]),
        .wr_data (resp),
        .rd_idx  (rd_ptr[IDX_W-1:0]),
        .rd_data (dec_bytes)
    );

    a_consume_valid: assert property (@(posedge clk) disable iff (!reset)
        !(dec_consume != 4'd0 && !dec_valid))
        else $fatal(1, "dec_consume while dec_valid low");

    a_resp_idle: assert property (@(posedge clk) disable iff (!reset)
        !(respcyc && state == IDLE))
        else $fatal(1, "respcyc while IDLE");

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: table of start addresses plus hand sequences
// for fill/back-pressure, ring wrap, redirect, drain and reset mid-burst.
module tb_inst_prefetch;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  entry = 64'h1000;
    logic         redirect = 1'b0;
    logic [63:0]  redirect_rip = '0;
    logic         reqcyc;
    logic [63:0]  req;
    logic         reqack = 1'b0;
    logic         respcyc = 1'b0;
    logic [63:0]  resp = '0;
    logic         respack;
    logic         dec_valid;
    logic [119:0] dec_bytes;
    logic [63:0]  dec_rip;
    logic [3:0]   dec_consume = '0;

    int tests = 0;
    int fails = 0;
    logic [63:0] m_rip;

    typedef struct {
        logic [63:0] entry;
        int unsigned ack_delay;
        logic [63:0] exp_req;
        int unsigned valid_beat;   // first beat index after which dec_valid is high (8 = not in this line)
    } vec_t;
    vec_t vecs[5];

    inst_prefetch dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redirect     (redirect),
        .redirect_rip (redirect_rip),
        .reqcyc       (reqcyc),
        .req          (req),
        .reqack       (reqack),
        .respcyc      (respcyc),
        .resp         (resp),
        .respack      (respack),
        .dec_valid    (dec_valid),
        .dec_bytes    (dec_bytes),
        .dec_rip      (dec_rip),
        .dec_consume  (dec_consume)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = mem_byte(a + 64'(i));
        return d;
    endfunction

    function automatic logic [119:0] window(input logic [63:0] a);
        logic [119:0] w;
        for (int i = 0; i < 15; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [63:0] exp);
        int n = 0;
        while (reqcyc !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("req_seen", reqcyc, 1'b1);
        chk("req_addr", req, exp);
    endtask

    task automatic send_beat(input logic [63:0] addr);
        respcyc = 1'b1;
        resp    = beat_data(addr);
        #1 chk("respack", respack, 1'b1);
        tick();
        respcyc = 1'b0;
    endtask

    task automatic serve_line(input logic [63:0] line, input int unsigned ack_delay,
                              input int unsigned valid_beat, input int unsigned nbeats);
        wait_req(line);
        repeat (ack_delay) begin
            tick();
            chk("req_held", {reqcyc, req}, {1'b1, line});
        end
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        chk("req_drop", reqcyc, 1'b0);
        for (int unsigned b = 0; b < nbeats; b++) begin
            send_beat(line + 64'(8*b));
            chk("dec_valid", dec_valid, b >= valid_beat);
            chk("dec_rip", dec_rip, m_rip);
            if (b >= valid_beat) chk("dec_bytes", dec_bytes, window(m_rip));
        end
    endtask

    task automatic consume(input int unsigned n);
        dec_consume = 4'(n);
        tick();
        dec_consume = '0;
        m_rip += 64'(n);
        chk("cons_rip", dec_rip, m_rip);
        chk("cons_valid", dec_valid, 1'b1);
        chk("cons_bytes", dec_bytes, window(m_rip));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{entry: 64'h1000, ack_delay: 2, exp_req: 64'h1000, valid_beat: 1};
        vecs[1] = '{entry: 64'h1013, ack_delay: 0, exp_req: 64'h1000, valid_beat: 4};
        vecs[2] = '{entry: 64'h203F, ack_delay: 1, exp_req: 64'h2000, valid_beat: 8};
        vecs[3] = '{entry: 64'h3008, ack_delay: 0, exp_req: 64'h3000, valid_beat: 2};
        vecs[4] = '{entry: 64'h4005, ack_delay: 3, exp_req: 64'h4000, valid_beat: 2};

        for (int v = 0; v < 5; v++) begin
            reset = 1'b0;
            entry = vecs[v].entry;
            tick();
            tick();
            chk("rst_reqcyc", reqcyc, 1'b0);
            chk("rst_req", req, 64'h0);
            chk("rst_valid", dec_valid, 1'b0);
            chk("rst_rip", dec_rip, vecs[v].entry);
            reset = 1'b1;
            m_rip = vecs[v].entry;
            tick();
            chk("first_req", reqcyc, 1'b1);
            serve_line(vecs[v].exp_req, vecs[v].ack_delay, vecs[v].valid_beat, 8);
            chk("post_line_idle", reqcyc, 1'b0);
            tick();
            chk("next_req", {reqcyc, req}, {1'b1, vecs[v].exp_req + 64'h40});
        end

        // Fill: two lines with no consume fill the ring and stop requests
        reset = 1'b0;
        entry = 64'h1000;
        tick();
        reset = 1'b1;
        m_rip = 64'h1000;
        serve_line(64'h1000, 1, 1, 8);
        serve_line(64'h1040, 0, 0, 8);
        repeat (6) begin
            tick();
            chk("full_noreq", reqcyc, 1'b0);
        end
        repeat (4) begin
            consume(15);
            chk("full_noreq", reqcyc, 1'b0);
        end
        consume(4);
        chk("free64_late", reqcyc, 1'b0);
        tick();
        chk("free64_req", {reqcyc, req}, {1'b1, 64'h1080});

        // Wrap: third line lands in ring 0-63; window read across index 127->0
        serve_line(64'h1080, 0, 0, 8);
        consume(15);
        consume(15);
        consume(15);
        consume(11);
        chk("wrap_rip", dec_rip, 64'h1078);
        repeat (3) consume(15);

        // Redirect on beat 4 with a same-cycle consume
        serve_line(64'h10C0, 0, 0, 4);
        respcyc      = 1'b1;
        resp         = beat_data(64'h10E0);
        redirect     = 1'b1;
        redirect_rip = 64'h2008;
        dec_consume  = 4'd15;
        tick();
        respcyc     = 1'b0;
        redirect    = 1'b0;
        dec_consume = '0;
        m_rip       = 64'h2008;
        chk("redir_valid", dec_valid, 1'b0);
        chk("redir_rip", dec_rip, 64'h2008);
        chk("redir_reqcyc", reqcyc, 1'b0);
        for (int unsigned b = 5; b < 8; b++) begin
            send_beat(64'h10C0 + 64'(8*b));
            chk("drain_valid", dec_valid, 1'b0);
            chk("drain_noreq", reqcyc, 1'b0);
        end
        serve_line(64'h2000, 0, 2, 8);

        // Reset mid-burst abandons the line and refetches from entry
        entry = 64'h5000;
        serve_line(64'h2040, 0, 0, 3);
        reset = 1'b0;
        #1;
        chk("midrst_reqcyc", reqcyc, 1'b0);
        chk("midrst_req", req, 64'h0);
        chk("midrst_valid", dec_valid, 1'b0);
        chk("midrst_rip", dec_rip, 64'h5000);
        tick();
        reset = 1'b1;
        m_rip = 64'h5000;
        tick();
        chk("midrst_first_req", {reqcyc, req}, {1'b1, 64'h5000});
        serve_line(64'h5000, 0, 1, 8);

        // Redirect in IDLE with same-cycle reqack: the accepted line must be drained
        wait_req(64'h5040);
        reqack       = 1'b1;
        redirect     = 1'b1;
        redirect_rip = 64'h6010;
        tick();
        reqack   = 1'b0;
        redirect = 1'b0;
        m_rip    = 64'h6010;
        chk("idle_redir_reqcyc", reqcyc, 1'b0);
        chk("idle_redir_rip", dec_rip, 64'h6010);
        for (int unsigned b = 0; b < 8; b++) begin
            send_beat(64'h5040 + 64'(8*b));
            chk("idle_drain_valid", dec_valid, 1'b0);
        end
        serve_line(64'h6000, 0, 3, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
